demux_1to8_stage: RTL

- Registered 1-to-8 demultiplexer with per-channel valid/ready handshakes. It is the distribution counterpart of the CPU's 8-to-1 select path.
- Accepts one word plus a 3-bit select from an upstream producer and presents it to exactly one of eight consumer channels, e.g. CPU write-back fan-out to peripheral/register-bank ports.
- One pipeline register stage. Full throughput when the target channel is ready.

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_1to8_stage_dec.sv | 13 +
 rtl/demux_1to8_stage.sv | 78 +++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-8 demux stage and its decoder.
package demux_pkg;

    localparam int NCH  = 8;
    localparam int SELW = 3;

    function automatic logic [NCH-1:0] onehot8(input logic [SELW-1:0] sel);
        onehot8      = '0;
        onehot8[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/demux_1to8_stage_dec.sv
// 3-to-8 combinational one-hot decoder (demux_onehot_dec), reusable outside the demux stage.
module demux_onehot_dec
    import demux_pkg::*;
(
    input  logic [SELW-1:0] sel,
    output logic [NCH-1:0]  onehot
);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_dec
        assign onehot[gi] = (sel == SELW'(gi));
    end

endmodule

// File: rtl/demux_1to8_stage.sv
// Registered 1-to-8 demultiplexer with per-channel valid/ready handshakes.
// Broadcast delivery to all eight channels is enabled by defining DEMUX_BCAST_EN.
module demux_1to8_stage
    import demux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SELW-1:0]  in_sel,
    input  logic             in_bcast,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SELW-1:0]  out_sel,
    output logic             busy
);

    logic [NCH-1:0]   pending_reg, pending_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [SELW-1:0]  sel_reg, sel_next;
    logic [NCH-1:0]   remain;
    logic [NCH-1:0]   sel_onehot;
    logic [NCH-1:0]   load_mask;
    logic             bcast_req;
    logic             accept;

    demux_onehot_dec u_dec (
        .sel    (in_sel),
        .onehot (sel_onehot)
    );

`ifdef DEMUX_BCAST_EN
    assign bcast_req = in_bcast;
`else
    // Broadcast disabled: the request is masked so every accept is unicast.
    assign bcast_req = in_bcast & 1'b0;
`endif

    assign load_mask = bcast_req ? {NCH{1'b1}} : sel_onehot;

    // Bits still outstanding after this edge; empty means the slot frees now.
    assign remain   = pending_reg & ~out_ready;
    assign in_ready = (remain == '0);
    assign accept   = in_valid & in_ready;

    always_comb begin
        pending_next = remain;
        data_next    = data_reg;
        sel_next     = sel_reg;
        if (accept) begin
            pending_next = load_mask;
            data_next    = in_data;
            sel_next     = in_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
            data_reg    <= '0;
            sel_reg     <= '0;
        end else begin
            pending_reg <= pending_next;
            data_reg    <= data_next;
            sel_reg     <= sel_next;
        end
    end

    assign out_valid = pending_reg;
    assign out_data  = data_reg;
    assign out_sel   = sel_reg;
    assign busy      = |pending_reg;

endmodule
